// File: rtl/tri_bus_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
// State encoding is exported so checkers can decode the debug state port.
package tri_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1 bit, so single-value counters still get a flop.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/tri_bus_arb_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    logic [W-1:0] pos;
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    // Walk from the farthest offset down so the nearest hit is the last one written.
    for (int off = N - 1; off >= 0; off--) begin
      pos = W'((int'(ptr) + off) % N);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arb.sv
// Round-robin owner sequencer for a shared tri_buf bus. Every owner change passes
// through TURN cycles plus one IDLE arbitration cycle with all enables low.
module tri_bus_arb
  import tri_bus_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int TURN     = 1,
  parameter int MAX_HOLD = 16,
  parameter int tech     = 4
) (
  input  logic                cp2,
  input  logic                ireset,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        bus_en,
  output logic [clog2(N)-1:0] owner,
  output logic                busy,
  output state_e              dbg_state
);

  localparam int OW = clog2(N);
  localparam int HW = clog2(MAX_HOLD);
  localparam int TW = clog2(TURN);

  localparam logic [OW-1:0] OWNER_LAST = OW'(N - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN - 1);

  if (N < 2 || N > 8 || TURN < 1 || MAX_HOLD < 2 || tech < 0) begin : g_bad_params
    $error("tri_bus_arb: parameter out of range");
  end

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [OW-1:0] ptr_q, ptr_d;

  logic          pick_valid;
  logic [OW-1:0] pick_idx;
  logic          other_req;
  logic          release_now;

  rr_pick #(
    .N (N),
    .W (OW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // req is a level: the owner keeps gnt while its req stays high, unless it has
  // held MAX_HOLD cycles and someone else is waiting.
  assign other_req   = |(req & ~gnt_q);
  assign release_now = !req[owner_q] || ((hold_q == HOLD_LAST) && other_req);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d         = ST_GRANT;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          busy_d          = 1'b1;
          hold_d          = '0;
        end
      end
      ST_GRANT: begin
        if (hold_q != HOLD_LAST) hold_d = hold_q + HW'(1);
        if (release_now) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          busy_d  = 1'b0;
          tcnt_d  = '0;
          ptr_d   = (owner_q == OWNER_LAST) ? '0 : owner_q + OW'(1);
        end
      end
      ST_TURN: begin
        if (tcnt_q == TURN_LAST) state_d = ST_IDLE;
        else                     tcnt_d  = tcnt_q + TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      tcnt_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign bus_en    = gnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tri_bus_arb.sv
// Bench for tri_bus_arb: three configurations (N/TURN/MAX_HOLD = 4/1/16, 2/3/4, 8/3/5)
// share clock and reset; each is compared every cycle to a per-owner behavioural model.
module tb_tri_bus_arb;
  import tri_bus_arb_pkg::*;

  localparam int NCFG = 3;

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [7:0] req_v [NCFG];

  logic [3:0] gnt0, en0;
  logic [1:0] own0;
  logic       busy0;
  state_e     st0;
  logic [1:0] gnt1, en1;
  logic [0:0] own1;
  logic       busy1;
  state_e     st1;
  logic [7:0] gnt2, en2;
  logic [2:0] own2;
  logic       busy2;
  state_e     st2;

  always #5 cp2 = ~cp2;

  tri_bus_arb #(.N(4), .TURN(1), .MAX_HOLD(16), .tech(4)) u_dut0 (
    .cp2(cp2), .ireset(ireset), .req(req_v[0][3:0]), .gnt(gnt0), .bus_en(en0),
    .owner(own0), .busy(busy0), .dbg_state(st0));
  tri_bus_arb #(.N(2), .TURN(3), .MAX_HOLD(4), .tech(4)) u_dut1 (
    .cp2(cp2), .ireset(ireset), .req(req_v[1][1:0]), .gnt(gnt1), .bus_en(en1),
    .owner(own1), .busy(busy1), .dbg_state(st1));
  tri_bus_arb #(.N(8), .TURN(3), .MAX_HOLD(5), .tech(4)) u_dut2 (
    .cp2(cp2), .ireset(ireset), .req(req_v[2]), .gnt(gnt2), .bus_en(en2),
    .owner(own2), .busy(busy2), .dbg_state(st2));

  function automatic int cfg_n(input int c);
    case (c) 0: return 4; 1: return 2; default: return 8; endcase
  endfunction
  function automatic int cfg_turn(input int c);
    case (c) 0: return 1; default: return 3; endcase
  endfunction
  function automatic int cfg_hold(input int c);
    case (c) 0: return 16; 1: return 4; default: return 5; endcase
  endfunction
  function automatic logic [7:0] cfg_mask(input int c);
    return 8'((1 << cfg_n(c)) - 1);
  endfunction

  function automatic logic [7:0] obs_gnt(input int c);
    case (c) 0: return {4'b0, gnt0}; 1: return {6'b0, gnt1}; default: return gnt2; endcase
  endfunction
  function automatic logic [7:0] obs_en(input int c);
    case (c) 0: return {4'b0, en0}; 1: return {6'b0, en1}; default: return en2; endcase
  endfunction
  function automatic logic [7:0] obs_own(input int c);
    case (c) 0: return {6'b0, own0}; 1: return {7'b0, own1}; default: return {5'b0, own2}; endcase
  endfunction
  function automatic logic obs_busy(input int c);
    case (c) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction
  function automatic state_e obs_st(input int c);
    case (c) 0: return st0; 1: return st1; default: return st2; endcase
  endfunction

  // Model: cur = owner index or -1, held = cycles owned, gap = enforced-low cycles left.
  typedef struct {
    int cur;
    int last;
    int held;
    int gap;
    int start;
  } mdl_t;

  mdl_t       m [NCFG];
  int         zero_run [NCFG];
  logic [7:0] prev_en [NCFG];
  bit         seen [NCFG];
  logic [2:0] exp_q [$];
  int         n_checks;
  int         n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      m[c]        = '{-1, 0, 0, 0, 0};
      zero_run[c] = 0;
      prev_en[c]  = '0;
      seen[c]     = 1'b0;
    end
  endtask

  task automatic model_step(input int c);
    int         n;
    int         i;
    logic [7:0] r;
    logic [7:0] others;
    n = cfg_n(c);
    r = req_v[c] & cfg_mask(c);
    if (m[c].cur >= 0) begin
      m[c].held++;
      others = r & ~(8'd1 << m[c].cur);
      if (r[3'(m[c].cur)] == 1'b0 || (m[c].held >= cfg_hold(c) && others != 0)) begin
        m[c].start = (m[c].cur + 1) % n;
        m[c].cur   = -1;
        m[c].gap   = cfg_turn(c);
      end
    end else if (m[c].gap > 0) begin
      m[c].gap--;
    end else begin
      for (int k = 0; k < n; k++) begin
        i = (m[c].start + k) % n;
        if (m[c].cur < 0 && r[3'(i)]) begin
          m[c].cur  = i;
          m[c].last = i;
          m[c].held = 0;
        end
      end
    end
  endtask

  task automatic check_cycle();
    logic [7:0] exp_g;
    logic [7:0] en;
    state_e     exp_st;
    for (int c = 0; c < NCFG; c++) begin
      exp_g  = (m[c].cur >= 0) ? (8'd1 << m[c].cur) : 8'd0;
      exp_st = (m[c].cur >= 0) ? ST_GRANT : ((m[c].gap > 0) ? ST_TURN : ST_IDLE);
      en     = obs_en(c);
      check($sformatf("c%0d gnt", c), 32'(obs_gnt(c)), 32'(exp_g));
      check($sformatf("c%0d bus_en", c), 32'(en), 32'(exp_g));
      check($sformatf("c%0d owner", c), 32'(obs_own(c)), 32'(m[c].last));
      check($sformatf("c%0d busy", c), 32'(obs_busy(c)), 32'(m[c].cur >= 0));
      check($sformatf("c%0d state", c), 32'(obs_st(c)), 32'(exp_st));
      check($sformatf("c%0d onehot", c), 32'($countones(en) <= 1), 32'(1));
      if (en != 0 && prev_en[c] == 0 && seen[c])
        check($sformatf("c%0d gap", c), 32'(zero_run[c] >= cfg_turn(c) + 1), 32'(1));
      if (en == 0) zero_run[c]++;
      else begin
        zero_run[c] = 0;
        seen[c]     = 1'b1;
      end
      prev_en[c] = en;
    end
  endtask

  task automatic tick();
    @(posedge cp2);
    for (int c = 0; c < NCFG; c++) model_step(c);
    @(negedge cp2);
    check_cycle();
  endtask

  // Called at a falling edge: reset lands mid-cycle so the async clear is visible.
  task automatic pulse_reset();
    #2 ireset = 1'b1;
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("c%0d async en", c), 32'(obs_en(c)), 32'(0));
      check($sformatf("c%0d async gnt", c), 32'(obs_gnt(c)), 32'(0));
      check($sformatf("c%0d async busy", c), 32'(obs_busy(c)), 32'(0));
      check($sformatf("c%0d async owner", c), 32'(obs_own(c)), 32'(0));
    end
    @(negedge cp2);
    ireset = 1'b0;
    model_reset();
    check_cycle();
  endtask

  initial begin
    logic [7:0] exp_en;
    logic [3:0] prev0;
    n_checks = 0;
    n_pass   = 0;
    ireset   = 1'b1;
    for (int c = 0; c < NCFG; c++) req_v[c] = '0;
    model_reset();
    @(negedge cp2);
    @(negedge cp2);
    ireset = 1'b0;
    check_cycle();

    // Single request, then reset while granted.
    req_v[0] = 8'b0100;
    tick();
    check("single gnt", 32'(gnt0), 32'(4'b0100));
    check("single en", 32'(en0), 32'(4'b0100));
    check("single owner", 32'(own0), 32'(2));
    check("single busy", 32'(busy0), 32'(1));
    pulse_reset();

    // All four requesting: 16-cycle tenures in order 0,1,2,3,0 with 2-cycle gaps.
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    req_v[0] = 8'h0F;
    prev0 = '0;
    for (int t = 0; t < 88; t++) begin
      tick();
      exp_en = ((t % 18) < 16) ? 8'(1 << ((t / 18) % 4)) : 8'd0;
      check("rr en", 32'(en0), 32'(exp_en));
      if (en0 != 0 && prev0 == 0 && exp_q.size() > 0)
        check("rr order", 32'(own0), 32'(exp_q.pop_front()));
      prev0 = en0;
    end
    check("rr order left", 32'(exp_q.size()), 32'(0));
    req_v[0] = '0;
    pulse_reset();

    // Handover: owner 1 drops with 3 pending.
    req_v[0] = 8'b0010;
    tick();
    check("ho first", 32'(en0), 32'(4'b0010));
    req_v[0] = 8'b1010;
    repeat (3) tick();
    req_v[0] = 8'b1000;
    tick();
    check("ho gap0", 32'(en0), 32'(0));
    tick();
    check("ho gap1", 32'(en0), 32'(0));
    tick();
    check("ho next", 32'(en0), 32'(4'b1000));
    req_v[0] = '0;
    pulse_reset();

    // Sole owner keeps the bus; a late competitor forces release next cycle.
    req_v[0] = 8'b0001;
    for (int t = 0; t < 100; t++) begin
      tick();
      check("sole hold", 32'(en0), 32'(4'b0001));
    end
    req_v[0] = 8'b0101;
    tick();
    check("sole release", 32'(en0), 32'(0));
    tick();
    check("sole gap", 32'(en0), 32'(0));
    tick();
    check("sole next", 32'(en0), 32'(4'b0100));
    req_v[0] = '0;
    pulse_reset();

    // Owner drops on the very edge the hold count saturates: one release only.
    req_v[0] = 8'b0011;
    tick();
    check("sim grant", 32'(en0), 32'(4'b0001));
    repeat (15) tick();
    check("sim held", 32'(en0), 32'(4'b0001));
    req_v[0] = 8'b0010;
    tick();
    check("sim rel", 32'(en0), 32'(0));
    tick();
    check("sim gap", 32'(en0), 32'(0));
    for (int t = 0; t < 4; t++) begin
      tick();
      check("sim next", 32'(en0), 32'(4'b0010));
    end
    req_v[0] = '0;
    pulse_reset();

    // N=2 and N=8 with TURN=3: 1-cycle grant latency, 4-cycle zero gap.
    req_v[1] = 8'b10;
    req_v[2] = 8'h20;
    tick();
    check("n2 lat", 32'(en1), 32'(2'b10));
    check("n8 lat", 32'(en2), 32'(8'h20));
    req_v[1] = 8'b11;
    req_v[2] = 8'h22;
    repeat (2) tick();
    req_v[1] = 8'b01;
    req_v[2] = 8'h02;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("n2 gap", 32'(en1), 32'(0));
      check("n8 gap", 32'(en2), 32'(0));
    end
    tick();
    check("n2 next", 32'(en1), 32'(2'b01));
    check("n8 next", 32'(en2), 32'(8'h02));
    for (int c = 0; c < NCFG; c++) req_v[c] = '0;
    pulse_reset();

    // Random sticky requests on all configurations.
    for (int t = 0; t < 10000; t++) begin
      for (int c = 0; c < NCFG; c++)
        if ($urandom_range(0, 7) == 0) req_v[c] = 8'($urandom) & cfg_mask(c);
      if (t == 5000) pulse_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
